mul_rr_sequencer: RTL and testbench

//  Shares one combinational array multiplier (array_mul_16bit_new) between N_REQ requesters.

---
 rtl/mul_ctrl_pkg.sv | 15 +
 rtl/mul_rr_sequencer_if.sv | 30 +++
 rtl/array_mul_16bit_new.sv | 18 +
 rtl/rr_pick.sv | 31 +++
 rtl/mul_rr_sequencer.sv | 117 +++++++++++
 tb/tb_mul_rr_sequencer.sv | 170 +++++++++++++++++
 6 files changed

// File: rtl/mul_ctrl_pkg.sv
// Shared types and helpers for the round-robin multiplier sequencer.
package mul_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } mul_state_t;

    // Index width that stays at least one bit even for a single entry.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mul_rr_sequencer_if.sv
// Request/response bundle between client blocks and the shared multiplier sequencer.
interface mul_rr_sequencer_if
    import mul_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4
);
    localparam int ID_W = id_width(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_ready;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [2*WIDTH-1:0]     rsp_mul;
    logic                   busy;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_mul, busy
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_mul, busy
    );

endinterface

// File: rtl/array_mul_16bit_new.sv
// Unsigned combinational array multiplier; ripple accumulation of shifted partial products.
module array_mul_16bit_new #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);
    always_comb begin
        p = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (b[i]) begin
                p = p + ({{WIDTH{1'b0}}, a} << i);
            end
        end
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, cyclically.
module rr_pick
    import mul_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]              req,
    input  logic [id_width(N)-1:0]    ptr,
    output logic [N-1:0]              gnt_onehot,
    output logic [id_width(N)-1:0]    gnt_idx,
    output logic                      any
);
    localparam int ID_W = id_width(N);

    always_comb begin
        int k;
        k          = 0;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!any && req[k]) begin
                any           = 1'b1;
                gnt_onehot[k] = 1'b1;
                gnt_idx       = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/mul_rr_sequencer.sv
// Shares one array multiplier between N_REQ requesters with round-robin arbitration;
// operands are held MUL_WAIT cycles so op_a/op_b -> rsp_mul is a MUL_WAIT-cycle multicycle path.
module mul_rr_sequencer
    import mul_ctrl_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int N_REQ    = 4,
    parameter int MUL_WAIT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_rr_sequencer_if.slave bus
);
    localparam int ID_W  = id_width(N_REQ);
    localparam int CNT_W = id_width(MUL_WAIT);

    if (MUL_WAIT < 1) begin : g_bad_wait
        $error("mul_rr_sequencer: MUL_WAIT must be >= 1");
    end
    if (N_REQ < 1) begin : g_bad_nreq
        $error("mul_rr_sequencer: N_REQ must be >= 1");
    end

    mul_state_t         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr, id_q, gnt_idx;
    logic [N_REQ-1:0]   gnt_onehot;
    logic               any;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   op_a, op_b;
    logic [2*WIDTH-1:0] mul_out;
    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [2*WIDTH-1:0] rsp_mul_q;
    logic               accept, capture, handshake;

    rr_pick #(.N(N_REQ)) u_pick (
        .req        (bus.req_valid),
        .ptr        (rr_ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    array_mul_16bit_new #(.WIDTH(WIDTH)) u_mul (
        .a (op_a),
        .b (op_b),
        .p (mul_out)
    );

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        capture   = 1'b0;
        handshake = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    accept  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    handshake = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr      <= '0;
            id_q        <= '0;
            cnt         <= '0;
            op_a        <= '0;
            op_b        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_mul_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_a   <= bus.req_a[int'(gnt_idx)*WIDTH +: WIDTH];
                op_b   <= bus.req_b[int'(gnt_idx)*WIDTH +: WIDTH];
                id_q   <= gnt_idx;
                rr_ptr <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
                cnt    <= CNT_W'(MUL_WAIT - 1);
            end else if (state_q == ST_WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                rsp_mul_q   <= mul_out;
                rsp_id_q    <= id_q;
                rsp_valid_q <= 1'b1;
            end else if (handshake) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    // Grants only in IDLE and never while reset is held, so no requester sees a phantom accept.
    assign bus.req_ready = (state_q == ST_IDLE && rst_n) ? gnt_onehot : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_mul   = rsp_mul_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul_rr_sequencer.sv
// Self-checking bench for mul_rr_sequencer (WIDTH=8, N_REQ=4, MUL_WAIT=2).
module tb_mul_rr_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mul_rr_sequencer_if #(.WIDTH(8), .N_REQ(4)) bus ();

    mul_rr_sequencer #(.WIDTH(8), .N_REQ(4), .MUL_WAIT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  gnt;
        logic [1:0]  id;
        logic [15:0] mul;
    } vec_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] mul;
    } exp_t;

    vec_t tbl[13];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int bp);
        exp_t e;
        int   lat;
        e = '0;
        bus.req_valid = v.mask;
        bus.req_a     = v.a;
        bus.req_b     = v.b;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready != 0) break;
            cycle();
        end
        check("grant", 64'(bus.req_ready), 64'(v.gnt));
        e.id  = v.id;
        e.mul = v.mul;
        sb.push_back(e);
        if (bp != 0) bus.rsp_ready = 1'b0;
        cycle();
        bus.req_a = $urandom;
        bus.req_b = $urandom;
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            check("wait_state", 64'({bus.busy, bus.req_ready}), 64'({1'b1, 4'b0000}));
            cycle();
            lat++;
        end
        check("latency", 64'(lat), 64'd2);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
        end
        check("rsp_id", 64'(bus.rsp_id), 64'(e.id));
        check("rsp_mul", 64'(bus.rsp_mul), 64'(e.mul));
        if (bp != 0) begin
            for (int i = 0; i < 5; i++) begin
                cycle();
                check("bp_hold", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_mul, bus.req_ready}),
                      64'({1'b1, e.id, e.mul, 4'b0000}));
            end
            bus.rsp_ready = 1'b1;
        end
        cycle();
        check("back_to_idle", 64'({bus.rsp_valid, bus.busy}), 64'd0);
        check("rsp_kept", 64'({bus.rsp_id, bus.rsp_mul}), 64'({e.id, e.mul}));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Fairness: a=k+1, b=3, all valid.
        tbl[0]  = '{4'b1111, 32'h04030201, 32'h03030303, 4'b0001, 2'd0, 16'd3};
        tbl[1]  = '{4'b1111, 32'h04030201, 32'h03030303, 4'b0010, 2'd1, 16'd6};
        tbl[2]  = '{4'b1111, 32'h04030201, 32'h03030303, 4'b0100, 2'd2, 16'd9};
        tbl[3]  = '{4'b1111, 32'h04030201, 32'h03030303, 4'b1000, 2'd3, 16'd12};
        tbl[4]  = '{4'b1111, 32'h04030201, 32'h03030303, 4'b0001, 2'd0, 16'd3};
        // Pointer wrap: grant 3, then only req 1 with a=0.
        tbl[5]  = '{4'b1000, 32'h07000000, 32'h09000000, 4'b1000, 2'd3, 16'd63};
        tbl[6]  = '{4'b0010, 32'h00000000, 32'h0000AA00, 4'b0010, 2'd1, 16'h0000};
        // Single request with full-scale operands.
        tbl[7]  = '{4'b0100, 32'h00FF0000, 32'h00FF0000, 4'b0100, 2'd2, 16'hFE01};
        tbl[8]  = '{4'b1001, 32'h800000FF, 32'h02000001, 4'b1000, 2'd3, 16'h0100};
        tbl[9]  = '{4'b1001, 32'h800000FF, 32'h02000001, 4'b0001, 2'd0, 16'h00FF};
        tbl[10] = '{4'b1110, 32'hEEDD1200, 32'h11223400, 4'b0010, 2'd1, 16'h03A8};
        // Backpressure vector and post-reset vector.
        tbl[11] = '{4'b1111, 32'h01C30101, 32'h017E0101, 4'b0100, 2'd2, 16'h5FFA};
        tbl[12] = '{4'b1111, 32'h0505050B, 32'h0505050D, 4'b0001, 2'd0, 16'h008F};

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("in_reset", 64'({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_mul, bus.busy}), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("idle_after_reset",
                  64'({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_mul, bus.busy}), 64'd0);
        end

        for (int i = 0; i < 11; i++) begin
            run_vec(tbl[i], 0);
        end

        run_vec(tbl[11], 1);

        // Abort a transaction in WAIT; pointer would otherwise pick requester 3 next.
        bus.req_valid = 4'b0100;
        bus.req_a     = 32'h00050000;
        bus.req_b     = 32'h00060000;
        #1;
        check("mid_grant", 64'(bus.req_ready), 64'(4'b0100));
        cycle();
        check("mid_busy", 64'(bus.busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset", 64'({bus.rsp_valid, bus.busy, bus.req_ready}), 64'd0);
        bus.req_valid = '0;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("no_rsp_after_abort", 64'({bus.rsp_valid, bus.busy}), 64'd0);
        end
        run_vec(tbl[12], 0);

        bus.req_valid = '0;
        cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
